// File: rtl/dmem_block_responder_pkg.sv
// dmem_block_responder_pkg: shared dcache block/address widths and a saturating-increment helper
//   DBLOCK_SIZE_BITS     : width of one cache block
//   DBLOCK_OFFSET_SIZE   : byte-offset bits stripped from a byte address
//   DMEM_BLOCK_ADDR_SIZE : width of a block address
package dmem_block_responder_pkg;
    localparam int DBLOCK_SIZE_BITS     = 128;
    localparam int DBLOCK_OFFSET_SIZE   = 4;
    localparam int DMEM_BLOCK_ADDR_SIZE = 32 - DBLOCK_OFFSET_SIZE;

    typedef logic [DBLOCK_SIZE_BITS-1:0]     dblock_t;
    typedef logic [DMEM_BLOCK_ADDR_SIZE-1:0] dblock_addr_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
        return (v == max) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/dmem_block_responder_if.sv
// dmem_block_responder_if: dcache-miss block memory handshake
//   master (dcache controller) : drives memRen/memWen/BlockAddr/memDin
//   slave  (memory responder)  : drives memDout/memReadReady/memWriteDone
interface dmem_block_responder_if
    import dmem_block_responder_pkg::*;
;
    logic         memRen;
    logic         memWen;
    dblock_addr_t BlockAddr;
    dblock_t      memDin;
    dblock_t      memDout;
    logic         memReadReady;
    logic         memWriteDone;

    modport master (
        output memRen, memWen, BlockAddr, memDin,
        input  memDout, memReadReady, memWriteDone
    );

    modport slave (
        input  memRen, memWen, BlockAddr, memDin,
        output memDout, memReadReady, memWriteDone
    );
endinterface

// File: rtl/dmem_block_array.sv
// dmem_block_array: single-port synchronous block RAM, one read or one write per cycle
//   clock, reset : clock; reset clears only the read-data register, never the array
//   re, we, addr : read enable, write enable, shared block index
//   wdata, rdata : write data in, registered read data out (holds between reads)
module dmem_block_array #(
    parameter int WIDTH      = 128,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  re,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_block_responder.sv
// dmem_block_responder: latency-programmable block memory responder for dcache misses
//   clock, reset         : single clock, synchronous active-high reset
//   bus (slave)          : memRen/memWen/BlockAddr/memDin in, memDout/memReadReady/memWriteDone out
//   busy                 : a request is in flight
//   protocolErr          : sticky, read and write requested together while idle
//   readCount/writeCount : saturating completed-request counters
module dmem_block_responder
    import dmem_block_responder_pkg::*;
#(
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 4,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    dmem_block_responder_if.slave bus,
    output logic                  busy,
    output logic                  protocolErr,
    output logic [15:0]           readCount,
    output logic [15:0]           writeCount
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    localparam logic [7:0]  RD_LOAD  = 8'(READ_LATENCY - 1);
    localparam logic [7:0]  WR_LOAD  = 8'(WRITE_LATENCY - 1);
    localparam logic [15:0] STAT_MAX = 16'((1 << STAT_WIDTH) - 1);

    state_t                    state;
    logic [7:0]                cnt;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    dblock_t                   wdata;
    dblock_t                   rdata;
    logic                      rd_fire;
    logic                      wr_fire;
    logic                      unused_addr_hi;

    // upper block-address bits alias onto the same array entry
    assign unused_addr_hi = ^bus.BlockAddr[DMEM_BLOCK_ADDR_SIZE-1:MEM_DEPTH_LOG2];

    // a dropped request line aborts, so it also blocks the final access
    assign rd_fire = state == RD_WAIT && bus.memRen && cnt == 8'd0;
    assign wr_fire = state == WR_WAIT && bus.memWen && cnt == 8'd0 && !reset;
    assign busy    = state != IDLE;
    assign bus.memDout = rdata;

    dmem_block_array #(
        .WIDTH      (DBLOCK_SIZE_BITS),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .re    (rd_fire),
        .we    (wr_fire),
        .addr  (idx),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.memReadReady <= 1'b0;
            bus.memWriteDone <= 1'b0;
            protocolErr      <= 1'b0;
            readCount        <= '0;
            writeCount       <= '0;
        end else begin
            bus.memReadReady <= rd_fire;
            bus.memWriteDone <= wr_fire;
            readCount        <= rd_fire ? sat_inc(readCount, STAT_MAX) : readCount;
            writeCount       <= wr_fire ? sat_inc(writeCount, STAT_MAX) : writeCount;
            case (state)
                IDLE: begin
                    // address/data are only consumed after an accept, so tracking them while idle is harmless
                    idx         <= bus.BlockAddr[MEM_DEPTH_LOG2-1:0];
                    wdata       <= bus.memDin;
                    cnt         <= bus.memWen ? WR_LOAD : RD_LOAD;
                    protocolErr <= protocolErr | (bus.memWen & bus.memRen);
                    state       <= bus.memWen ? WR_WAIT : bus.memRen ? RD_WAIT : IDLE;
                end
                RD_WAIT: begin
                    cnt   <= cnt - 8'd1;
                    state <= !bus.memRen ? IDLE : rd_fire ? RD_DONE : RD_WAIT;
                end
                WR_WAIT: begin
                    cnt   <= cnt - 8'd1;
                    state <= !bus.memWen ? IDLE : wr_fire ? WR_DONE : WR_WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_block_responder.sv
// tb_dmem_block_responder: directed + randomized checks of three responder instances against a reference model
module tb_dmem_block_responder;
    import dmem_block_responder_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         ren   [3];
    logic         wen   [3];
    dblock_addr_t addr  [3];
    dblock_t      din   [3];
    dblock_t      dout  [3];
    logic         rdy   [3];
    logic         dn    [3];
    logic         bsy   [3];
    logic         perr  [3];
    logic [15:0]  rc    [3];
    logic [15:0]  wc    [3];

    always #5 clock = ~clock;

    // instance 0: latency 4; instance 1: latency 1 with 4-bit stats; instance 2: latency 255
    for (genvar g = 0; g < 3; g++) begin : u
        dmem_block_responder_if bus ();
        assign bus.memRen    = ren[g];
        assign bus.memWen    = wen[g];
        assign bus.BlockAddr = addr[g];
        assign bus.memDin    = din[g];
        assign dout[g]       = bus.memDout;
        assign rdy[g]        = bus.memReadReady;
        assign dn[g]         = bus.memWriteDone;
        dmem_block_responder #(
            .READ_LATENCY   (g == 0 ? 4 : g == 1 ? 1 : 255),
            .WRITE_LATENCY  (g == 0 ? 4 : g == 1 ? 1 : 255),
            .MEM_DEPTH_LOG2 (10),
            .STAT_WIDTH     (g == 1 ? 4 : 16)
        ) dut (
            .clock       (clock),
            .reset       (reset),
            .bus         (bus),
            .busy        (bsy[g]),
            .protocolErr (perr[g]),
            .readCount   (rc[g]),
            .writeCount  (wc[g])
        );
    end

    int      vectors;
    int      miscompares;
    dblock_t mem_m [int];
    int      rc_m [3];
    int      wc_m [3];
    logic    perr_m [3];
    dblock_t dout_m [3];
    int      written [$];

    function automatic int lat_of(input int i);
        return i == 0 ? 4 : i == 1 ? 1 : 255;
    endfunction

    function automatic int sat(input int v, input int i);
        return v == (i == 1 ? 15 : 65535) ? v : v + 1;
    endfunction

    function automatic int key_of(input int i, input dblock_addr_t a);
        return i * 1024 + int'(a[9:0]);
    endfunction

    function automatic dblock_t rnd_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            rc_m[i] = 0;
            wc_m[i] = 0;
            perr_m[i] = 1'b0;
            dout_m[i] = '0;
        end
    endtask

    task automatic check_status(input int i);
        chk("read_count", 128'(rc[i]), 128'(rc_m[i]));
        chk("write_count", 128'(wc[i]), 128'(wc_m[i]));
        chk("protocol_err", 128'(perr[i]), 128'(perr_m[i]));
        chk("dout_hold", dout[i], dout_m[i]);
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", 128'(bsy[i]), 128'(0));
            chk("reset_ready", 128'(rdy[i]), 128'(0));
            chk("reset_done", 128'(dn[i]), 128'(0));
            check_status(i);
        end
    endtask

    // full request: accept, wait for the pulse with a bound, check timing/data/stats
    task automatic transact(input int i, input bit wr, input bit both, input bit hold,
                            input dblock_addr_t a, input dblock_t d);
        int n;
        bit seen;
        int key;
        n = 0;
        seen = 1'b0;
        key = key_of(i, a);
        ren[i] = !wr || both;
        wen[i] = wr;
        addr[i] = a;
        din[i] = d;
        tick();
        chk("busy_at_accept", 128'(bsy[i]), 128'(1));
        addr[i] = dblock_addr_t'($urandom);
        din[i] = rnd_block();
        while (!seen && n < 300) begin
            tick();
            n++;
            seen = wr ? dn[i] : rdy[i];
            if (!seen) chk("busy_wait", 128'(bsy[i]), 128'(1));
        end
        chk("latency", 128'(n), 128'(lat_of(i)));
        chk("other_pulse", 128'(wr ? rdy[i] : dn[i]), 128'(0));
        if (wr) begin
            mem_m[key] = d;
            wc_m[i] = sat(wc_m[i], i);
            if (both) perr_m[i] = 1'b1;
        end else begin
            chk("read_data", dout[i], mem_m[key]);
            rc_m[i] = sat(rc_m[i], i);
            dout_m[i] = mem_m[key];
        end
        if (!hold) begin
            ren[i] = 1'b0;
            wen[i] = 1'b0;
        end
        tick();
        chk("pulse_width", 128'(wr ? dn[i] : rdy[i]), 128'(0));
        chk("idle_after_done", 128'(bsy[i]), 128'(0));
        check_status(i);
    endtask

    task automatic abort_req(input int i, input bit wr, input dblock_addr_t a, input dblock_t d, input int k);
        ren[i] = !wr;
        wen[i] = wr;
        addr[i] = a;
        din[i] = d;
        tick();
        repeat (k) begin
            tick();
            chk("abort_wait_no_pulse", 128'(rdy[i] | dn[i]), 128'(0));
        end
        ren[i] = 1'b0;
        wen[i] = 1'b0;
        tick();
        chk("abort_idle", 128'(bsy[i]), 128'(0));
        repeat (3) begin
            tick();
            chk("abort_no_pulse", 128'(rdy[i] | dn[i]), 128'(0));
        end
        check_status(i);
    endtask

    initial begin
        dblock_t      v7;
        dblock_addr_t a;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ren[i] = 1'b0;
            wen[i] = 1'b0;
            addr[i] = '0;
            din[i] = '0;
        end
        model_reset();
        repeat (3) tick();
        check_reset_state();
        reset = 1'b0;
        tick();

        // write then read, plus an aliased read of the same index
        transact(0, 1, 0, 0, 28'h5, 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF);
        transact(0, 0, 0, 0, 28'h5, '0);
        transact(0, 0, 0, 0, 28'hABC0405, '0);

        // latency extremes
        transact(1, 1, 0, 0, 28'h11, rnd_block());
        transact(1, 0, 0, 0, 28'h11, '0);
        transact(2, 1, 0, 0, 28'h22, rnd_block());
        transact(2, 0, 0, 0, 28'h22, '0);

        // simultaneous request: write wins, error is sticky
        transact(0, 1, 1, 0, 28'h3, '1);
        repeat (10) tick();
        chk("perr_sticky", 128'(perr[0]), 128'(1));
        transact(0, 0, 0, 0, 28'h3, '0);

        // aborted read and aborted write leave memory and stats untouched
        abort_req(0, 0, 28'h5, '0, 2);
        transact(0, 0, 0, 0, 28'h5, '0);
        abort_req(0, 1, 28'h5, rnd_block(), 2);
        transact(0, 0, 0, 0, 28'h5, '0);

        // back-to-back held requests; 4-bit stats saturate at 15
        for (int r = 0; r < 18; r++) transact(1, 0, 0, 1, 28'h11, '0);
        ren[1] = 1'b0;
        tick();
        for (int r = 0; r < 18; r++) transact(1, 1, 0, 1, 28'h40 + 28'(r % 3), rnd_block());
        wen[1] = 1'b0;
        tick();
        transact(1, 0, 0, 0, 28'h41, '0);

        // reset arriving on the edge the write would commit
        v7 = rnd_block();
        transact(0, 1, 0, 0, 28'h7, v7);
        wen[0] = 1'b1;
        addr[0] = 28'h7;
        din[0] = ~v7;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        wen[0] = 1'b0;
        model_reset();
        check_reset_state();
        reset = 1'b0;
        tick();
        transact(0, 0, 0, 0, 28'h7, '0);

        // randomized traffic on instance 0 with aliased upper address bits
        written.push_back(5);
        written.push_back(3);
        written.push_back(7);
        for (int r = 0; r < 40; r++) begin
            bit wr;
            wr = $urandom_range(1, 0) == 1;
            a = dblock_addr_t'($urandom);
            if (wr) begin
                a[9:0] = 10'($urandom_range(15, 0) * 37);
                written.push_back(int'(a[9:0]));
                transact(0, 1, $urandom_range(7, 0) == 0, 0, a, rnd_block());
            end else begin
                a[9:0] = 10'(written[$urandom_range(written.size() - 1, 0)]);
                transact(0, 0, 0, 0, a, '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
